// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that lets NCORES cores share one external memory bus.
// One transaction at a time: IDLE -> ALE -> ACCESS (WAIT+1 cycles) -> DONE -> IDLE.
module mem_bus_arbiter #(
    parameter int NCORES = 4,
    parameter int DW     = 64,
    parameter int AW     = 64,
    parameter int WAIT   = 2
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic [NCORES-1:0]    Req,
    input  logic [NCORES-1:0]    RnW_in,
    input  logic [NCORES*AW-1:0] Addr_in,
    input  logic [NCORES*DW-1:0] Wdata_in,
    output logic [NCORES-1:0]    Ack,
    output logic [NCORES-1:0]    Grant,
    output logic [DW-1:0]        Rdata,
    output logic [AW-1:0]        Addr,
    output logic [DW-1:0]        Dout,
    input  logic [DW-1:0]        Din,
    output logic                 nALE,
    output logic                 nME,
    output logic                 nOE,
    output logic                 RnW
);

    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [3:0] WAIT_C = 4'(WAIT);
    localparam logic [NCORES-1:0] ONE_C = {{(NCORES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ALE    = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [AW-1:0]     addr_lat_q, addr_lat_d;
    logic [DW-1:0]     wdata_lat_q, wdata_lat_d;
    logic              rnw_lat_q, rnw_lat_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [IW-1:0]     pick_s;

    logic              nale_q, nale_d, nme_q, nme_d, noe_q, noe_d, rnw_q, rnw_d;
    logic [NCORES-1:0] grant_q, grant_d, ack_q, ack_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     dout_q, dout_d;

    // Search starts just after the last winner and wraps, so every requester is served within NCORES grants.
    function automatic logic [IW-1:0] rr_pick(input logic [NCORES-1:0] req, input logic [IW-1:0] last);
        logic [IW-1:0] pick;
        logic          hit;
        int            idx;
        pick = last;
        hit  = 1'b0;
        for (int k = 1; k <= NCORES; k++) begin
            idx = (int'(last) + k) % NCORES;
            if (!hit && req[idx]) begin
                pick = IW'(idx);
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

    assign pick_s = rr_pick(Req, ptr_q);

    // State, transaction latches and output registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            ptr_q       <= IW'(NCORES - 1);
            gidx_q      <= '0;
            addr_lat_q  <= '0;
            wdata_lat_q <= '0;
            rnw_lat_q   <= 1'b1;
            cnt_q       <= 4'd0;
            rdata_q     <= '0;
            nale_q      <= 1'b1;
            nme_q       <= 1'b1;
            noe_q       <= 1'b1;
            rnw_q       <= 1'b1;
            grant_q     <= '0;
            ack_q       <= '0;
            addr_q      <= '0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            addr_lat_q  <= addr_lat_d;
            wdata_lat_q <= wdata_lat_d;
            rnw_lat_q   <= rnw_lat_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            nale_q      <= nale_d;
            nme_q       <= nme_d;
            noe_q       <= noe_d;
            rnw_q       <= rnw_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
        end
    end

    // Next state; requests are only looked at in IDLE, so the owner may drop Req mid-transaction.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        addr_lat_d  = addr_lat_q;
        wdata_lat_d = wdata_lat_q;
        rnw_lat_d   = rnw_lat_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (|Req) begin
                    gidx_d      = pick_s;
                    addr_lat_d  = Addr_in[int'(pick_s)*AW +: AW];
                    wdata_lat_d = Wdata_in[int'(pick_s)*DW +: DW];
                    rnw_lat_d   = RnW_in[pick_s];
                    state_d     = S_ALE;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_ALE: begin
                cnt_d   = 4'd0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == WAIT_C) begin
                    state_d = S_DONE;
                    if (rnw_lat_q) begin
                        rdata_d = Din;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                ptr_d   = gidx_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that they are registered and line up with it.
    always_comb begin
        nale_d  = 1'b1;
        nme_d   = 1'b1;
        noe_d   = 1'b1;
        rnw_d   = 1'b1;
        grant_d = '0;
        ack_d   = '0;
        addr_d  = '0;
        dout_d  = '0;
        case (state_d)
            S_ALE: begin
                nale_d  = 1'b0;
                addr_d  = addr_lat_d;
                grant_d = ONE_C << gidx_d;
            end
            S_ACCESS: begin
                nme_d   = 1'b0;
                rnw_d   = rnw_lat_d;
                noe_d   = ~rnw_lat_d;
                addr_d  = addr_lat_d;
                grant_d = ONE_C << gidx_d;
                if (rnw_lat_d) begin
                    dout_d = '0;
                end else begin
                    dout_d = wdata_lat_d;
                end
            end
            S_DONE: begin
                addr_d  = addr_lat_d;
                grant_d = ONE_C << gidx_d;
                ack_d   = ONE_C << gidx_d;
            end
            default: begin
                nale_d  = 1'b1;
            end
        endcase
    end

    assign Ack   = ack_q;
    assign Grant = grant_q;
    assign Rdata = rdata_q;
    assign Addr  = addr_q;
    assign Dout  = dout_q;
    assign nALE  = nale_q;
    assign nME   = nme_q;
    assign nOE   = noe_q;
    assign RnW   = rnw_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a 4-core WAIT=2 instance and a 2-core WAIT=0 instance,
// with expected Ack/Rdata results queued at stimulus time and checked when Ack fires.
module tb_mem_bus_arbiter;

    localparam int N = 4, DW = 64, AW = 64, WT = 2;
    localparam int NB = 2, DWB = 32, AWB = 16;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic              nReset;
    logic [N-1:0]      Req, RnW_in, Ack, Grant;
    logic [N*AW-1:0]   Addr_in;
    logic [N*DW-1:0]   Wdata_in;
    logic [DW-1:0]     Rdata, Dout, Din;
    logic [AW-1:0]     Addr;
    logic              nALE, nME, nOE, RnW;

    logic [NB-1:0]     Req_b, RnW_in_b, Ack_b, Grant_b;
    logic [NB*AWB-1:0] Addr_in_b;
    logic [NB*DWB-1:0] Wdata_in_b;
    logic [DWB-1:0]    Rdata_b, Dout_b, Din_b;
    logic [AWB-1:0]    Addr_b;
    logic              nALE_b, nME_b, nOE_b, RnW_b;

    mem_bus_arbiter #(.NCORES(N), .DW(DW), .AW(AW), .WAIT(WT)) dut (
        .Clock(Clock), .nReset(nReset), .Req(Req), .RnW_in(RnW_in), .Addr_in(Addr_in),
        .Wdata_in(Wdata_in), .Ack(Ack), .Grant(Grant), .Rdata(Rdata), .Addr(Addr),
        .Dout(Dout), .Din(Din), .nALE(nALE), .nME(nME), .nOE(nOE), .RnW(RnW)
    );

    mem_bus_arbiter #(.NCORES(NB), .DW(DWB), .AW(AWB), .WAIT(0)) dut_b (
        .Clock(Clock), .nReset(nReset), .Req(Req_b), .RnW_in(RnW_in_b), .Addr_in(Addr_in_b),
        .Wdata_in(Wdata_in_b), .Ack(Ack_b), .Grant(Grant_b), .Rdata(Rdata_b), .Addr(Addr_b),
        .Dout(Dout_b), .Din(Din_b), .nALE(nALE_b), .nME(nME_b), .nOE(nOE_b), .RnW(RnW_b)
    );

    typedef struct {
        int          core;
        logic [63:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] rd_model;
    logic [63:0] a_addr[N];
    logic [63:0] a_wdata[N];
    logic        a_rnw[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh4(input int g);
        logic [N-1:0] one;
        one = 4'b0001;
        return one << g;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            Addr_in[i*AW +: AW]  = a_addr[i];
            Wdata_in[i*DW +: DW] = a_wdata[i];
            RnW_in[i]            = a_rnw[i];
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_nALE"}, 64'(nALE), 64'd1);
        chk({tag, "_nME"}, 64'(nME), 64'd1);
        chk({tag, "_nOE"}, 64'(nOE), 64'd1);
        chk({tag, "_RnW"}, 64'(RnW), 64'd1);
        chk({tag, "_Grant"}, 64'(Grant), 64'd0);
        chk({tag, "_Ack"}, 64'(Ack), 64'd0);
        chk({tag, "_Addr"}, Addr, 64'd0);
        chk({tag, "_Dout"}, Dout, 64'd0);
    endtask

    // One full transaction on the 4-core instance; entered at a negedge just before grant edge E.
    task automatic txn(input int g, input int drop_at, input logic [63:0] din_val);
        logic [63:0] e_addr, e_wdata;
        logic        e_rnw;
        exp_t        e, got;
        e_addr  = a_addr[g];
        e_wdata = a_wdata[g];
        e_rnw   = a_rnw[g];
        if (e_rnw) rd_model = din_val;
        e.core  = g;
        e.rdata = rd_model;
        sb.push_back(e);
        @(negedge Clock);
        chk("ale_nALE", 64'(nALE), 64'd0);
        chk("ale_nME", 64'(nME), 64'd1);
        chk("ale_grant", 64'(Grant), 64'(oh4(g)));
        chk("ale_addr", Addr, e_addr);
        Addr_in  = ~Addr_in;
        Wdata_in = ~Wdata_in;
        RnW_in   = ~RnW_in;
        Din      = ~din_val;
        for (int c = 2; c <= WT + 2; c++) begin
            @(negedge Clock);
            if (c == drop_at) Req[g] = 1'b0;
            chk("acc_nME", 64'(nME), 64'd0);
            chk("acc_nALE", 64'(nALE), 64'd1);
            chk("acc_nOE", 64'(nOE), 64'(!e_rnw));
            chk("acc_RnW", 64'(RnW), 64'(e_rnw));
            chk("acc_Dout", Dout, e_rnw ? 64'd0 : e_wdata);
            chk("acc_grant", 64'(Grant), 64'(oh4(g)));
            chk("acc_ack", 64'(Ack), 64'd0);
            if (c == WT + 2) Din = din_val;
        end
        @(negedge Clock);
        Din = ~din_val;
        got = sb.pop_front();
        chk("done_ack", 64'(Ack), 64'(oh4(got.core)));
        chk("done_rdata", Rdata, got.rdata);
        chk("done_grant", 64'(Grant), 64'(oh4(got.core)));
        chk("done_nME", 64'(nME), 64'd1);
        chk("done_nOE", 64'(nOE), 64'd1);
        Req[g] = 1'b0;
        apply();
        @(negedge Clock);
        chk_idle("gap");
    endtask

    initial begin
        exp_t eb, gb;
        nReset     = 1'b0;
        Req        = '0;
        Din        = '0;
        Req_b      = '0;
        RnW_in_b   = 2'b11;
        Addr_in_b  = {16'h0B11, 16'h0B00};
        Wdata_in_b = '0;
        Din_b      = '0;
        rd_model   = 64'd0;
        for (int i = 0; i < N; i++) begin
            a_addr[i]  = 64'h1000 + 64'(i);
            a_wdata[i] = 64'hA5A5_0000 + 64'(i);
            a_rnw[i]   = 1'b1;
        end
        apply();
        repeat (2) @(negedge Clock);
        chk_idle("rst");
        chk("rst_rdata", Rdata, 64'd0);
        chk("rst_b_grant", 64'(Grant_b), 64'd0);
        nReset = 1'b1;
        @(negedge Clock);

        // Single read by core 0.
        a_rnw[0]  = 1'b1;
        a_addr[0] = 64'h100;
        apply();
        Req = 4'b0001;
        txn(0, 0, 64'hDEAD_BEEF);

        // Reset so the pointer restarts at core 0, then all four request at once.
        nReset = 1'b0;
        @(negedge Clock);
        nReset   = 1'b1;
        rd_model = 64'd0;
        @(negedge Clock);
        chk("rst2_rdata", Rdata, 64'd0);
        for (int i = 0; i < N; i++) a_addr[i] = 64'h200 + 64'(i);
        apply();
        Req = 4'b1111;
        for (int i = 0; i < N; i++) txn(i, 0, 64'hC0DE_0000 + 64'(i));

        // Core 2 write: Rdata must keep the last read value.
        a_rnw[2]   = 1'b0;
        a_wdata[2] = 64'h55AA;
        apply();
        Req = 4'b0100;
        txn(2, 0, 64'h0BAD);

        // Core 1 drops Req during ACCESS; Ack must still come.
        a_rnw[1]  = 1'b1;
        a_addr[1] = 64'h300;
        apply();
        Req = 4'b0010;
        txn(1, 2, 64'h1234);

        // Reset in the middle of ACCESS aborts with no Ack.
        Req = 4'b0010;
        @(negedge Clock);
        @(negedge Clock);
        chk("abort_pre_nME", 64'(nME), 64'd0);
        nReset = 1'b0;
        #1;
        chk_idle("abort");
        chk("abort_rdata", Rdata, 64'd0);
        @(negedge Clock);
        chk("abort_ack", 64'(Ack), 64'd0);
        rd_model = 64'd0;
        Req      = 4'b1000;
        a_addr[3] = 64'h3333;
        apply();
        nReset = 1'b1;
        txn(3, 0, 64'h7777_8888);

        // WAIT=0, two cores both requesting: grants alternate, ACCESS is one cycle.
        Req_b = 2'b11;
        for (int t = 0; t < 4; t++) begin
            eb.core  = t % 2;
            eb.rdata = 64'h0000_0000_A000_0000 + 64'(t);
            sb.push_back(eb);
            @(negedge Clock);
            chk("b_ale_nALE", 64'(nALE_b), 64'd0);
            chk("b_ale_grant", 64'(Grant_b), 64'(2'b01 << (t % 2)));
            chk("b_ale_addr", 64'(Addr_b), 64'(Addr_in_b[(t % 2)*AWB +: AWB]));
            @(negedge Clock);
            chk("b_acc_nME", 64'(nME_b), 64'd0);
            chk("b_acc_nOE", 64'(nOE_b), 64'd0);
            chk("b_acc_ack", 64'(Ack_b), 64'd0);
            Din_b = 32'hA000_0000 + 32'(t);
            @(negedge Clock);
            gb = sb.pop_front();
            chk("b_done_ack", 64'(Ack_b), 64'(2'b01 << gb.core));
            chk("b_done_rdata", 64'(Rdata_b), gb.rdata);
            chk("b_done_nME", 64'(nME_b), 64'd1);
            Din_b = 32'hFFFF_FFFF;
            Req_b[t % 2] = 1'b0;
            @(negedge Clock);
            chk("b_gap_grant", 64'(Grant_b), 64'd0);
            chk("b_gap_nALE", 64'(nALE_b), 64'd1);
            Req_b[t % 2] = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter NCORES, default 4: number of requesting cores, 2..8.
REQ-002 SHALL have parameter DW, default 64: data width.
REQ-003 SHALL have parameter AW, default 64: address width.
REQ-004 SHALL have parameter WAIT, default 2: extra memory wait cycles, 0..15.
REQ-005 SHALL have port Clock, in, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port nReset, in, 1: asynchronous, active-low reset.
REQ-007 SHALL have port Req, in, NCORES: per-core request, held high until that core's Ack.
REQ-008 SHALL have port RnW_in, in, NCORES: per-core direction, 1=read, 0=write.
REQ-009 SHALL have port Addr_in, in, NCORES*AW: per-core address, core i at bits [i*AW +: AW].
REQ-010 SHALL have port Wdata_in, in, NCORES*DW: per-core write data, same packing.
REQ-011 SHALL have port Ack, out, NCORES: one-cycle completion pulse per core.
REQ-012 SHALL have port Grant, out, NCORES: one-hot bus owner, zero when idle.
REQ-013 SHALL have port Rdata, out, DW: read data, valid while Ack is high.
REQ-014 SHALL have port Addr, out, AW: external memory address.
REQ-015 SHALL have port Dout, out, DW: external write data.
REQ-016 SHALL have port Din, in, DW: external read data.
REQ-017 SHALL have ports nALE, nME, nOE, RnW, out, 1 each: external memory strobes, as in the core bus.

Function
REQ-018 SHALL implement FSM IDLE->ALE->ACCESS->DONE->IDLE, one transaction at a time.
REQ-019 SHALL, in IDLE with any Req high, grant round-robin:
- search starts at index ptr+1 and wraps modulo NCORES;
- ptr is the last granted index.
REQ-020 SHALL, on the grant edge, latch the granted index, Addr_in slice, Wdata_in slice and RnW_in bit; later input changes are ignored until DONE.
REQ-021 SHALL drive these registered outputs per state:
- ALE, 1 cycle: nALE=0, Addr=latched address, Grant one-hot;
- ACCESS, WAIT+1 cycles: nME=0, RnW=latched direction, nOE=0 on reads only, Dout=latched data on writes only;
- DONE, 1 cycle: Ack[g]=1, strobes inactive, Grant held;
- ptr<=g on exit from DONE.
REQ-022 SHALL meet this timing when Req is sampled at IDLE edge E:
- nALE low in cycle E+1;
- nME low in cycles E+2..E+WAIT+2;
- Ack high in cycle E+WAIT+3;
- idle for one cycle E+WAIT+4 before the next grant.
REQ-023 SHALL capture Din into Rdata on the rising edge that ends the last ACCESS cycle of a read; Rdata SHALL be unchanged by writes.
REQ-024 SHALL ignore Req in ALE, ACCESS and DONE; simultaneous requests are resolved only in IDLE.
REQ-025 SHALL, if the owner drops Req mid-transaction, still complete the transaction and pulse Ack.
REQ-026 SHALL, with WAIT=0, hold ACCESS for exactly one cycle.
REQ-027 SHALL hold these idle values in IDLE: nALE=nME=nOE=RnW=1, Grant=0, Ack=0, Addr=0, Dout=0.
REQ-028 SHALL keep Ack and Grant each at most one-hot at all times.

Reset
REQ-029 SHALL, on nReset low at any time, immediately force:
- state=IDLE, ptr=NCORES-1 (so core 0 wins first), wait counter=0, Rdata=0;
- all outputs to their REQ-027 values.
REQ-030 SHALL abort any in-flight transaction on reset without an Ack; the first grant after reset release follows REQ-019.

Verification
REQ-031 SHALL check: reset, then Req=4'b0001, read, Addr_in[0]=0x100, Din=0xDEADBEEF at the capture edge -> nALE low 1 cycle, nME/nOE low 3 cycles, Ack=4'b0001 with Rdata=0xDEADBEEF in cycle E+5.
REQ-032 SHALL check: Req=4'b1111 held, each core dropping Req on its Ack -> Grant order 0,1,2,3, six cycles per transaction.
REQ-033 SHALL check: core 2 write, Wdata_in[2]=0x55AA -> Dout=0x55AA and RnW=0 during ACCESS, nOE stays 1, Rdata unchanged.
REQ-034 SHALL check: core 1 drops Req in cycle E+2 -> Ack[1] still pulses in cycle E+5.
REQ-035 SHALL check: nReset low in ACCESS -> all outputs return to idle values at once, no Ack; after release, Req=4'b1000 -> Grant=4'b1000.
REQ-036 SHALL check: rebuild with WAIT=0, NCORES=2 -> nME low for exactly 1 cycle, Ack in cycle E+3, Grant alternates between cores.
